ps2_word_capture: RTL and testbench
===================================

// Module: ps2_word_capture
// PURPOSE
//  Successor to single-byte scan-code latch: consumes PS2_Controller byte stream, decodes set-2 make/break/E0
//  framing, buffers up to DEPTH letter make codes as a word, supports backspace/enter editing.
//  Sits between PS2_Controller and letter-checking logic; also drives last-code for HEX display.
// PARAMETERS
//  DEPTH        4   max letters held in word buffer (1..16)
//  CNT_W        3   width of letter_count; must hold 0..DEPTH
//  REPEAT_BLOCK 1   1: ignore typematic repeats of held key until its break; 0: accept every make
// PORTS
//  CLOCK_50      in   1          system clock, all logic posedge
//  KEY           in   1          KEY[0]: asynchronous active-low reset
//  ps2_key_data  in   8          byte from PS2_Controller received_data
//  ps2_key_pressed in 1          1-cycle strobe, ps2_key_data valid
//  word_ack      in   1          consumer accepts word; clears buffer
//  word_codes    out  8*DEPTH    letter make codes; slot 0 = bits[7:0] = first letter; unused slots 8'h00
//  letter_count  out  CNT_W      number of letters held
//  word_valid    out  1          word committed by Enter, held until word_ack
//  letter_strobe out  1          1-cycle pulse when a letter is appended
//  last_code     out  8          last accepted make code (any key, non-E0) for HEX0/HEX1
//  buf_full      out  1          letter_count == DEPTH
//  overflow      out  1          sticky: letter dropped while full; cleared by word_ack or reset
// BEHAVIOUR
//  Reset (KEY[0]=0, async): all outputs 0, word_codes all 8'h00, FSM=IDLE, held code 8'h00.
//  Decoder FSM, advances only on ps2_key_pressed:
//   IDLE: F0->BRK; E0->EXT; other byte = make code -> process(make).
//   BRK: any byte = break of that code; if equals held code, held<=00; ->IDLE. No buffer change.
//   EXT: F0->EXT_BRK; other byte = extended make, ignored; ->IDLE.
//   EXT_BRK: any byte ignored; ->IDLE.
//  process(make), in order, evaluated same cycle as strobe:
//   - REPEAT_BLOCK=1 and make==held: discard entirely (last_code unchanged).
//   - else held<=make, last_code<=make.
//   - word_valid=1: no buffer edit (buffer frozen until ack).
//   - letter (set-2 A..Z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A):
//     count<DEPTH -> slot[count]<=make, count+1, letter_strobe next cycle; else overflow<=1, drop.
//   - 8'h66 Backspace: count>0 -> slot[count-1]<=00, count-1; count==0 -> no-op.
//   - 8'h5A Enter: count>0 -> word_valid<=1; count==0 -> no-op.
//   - any other code: last_code only.
//  Latency: outputs update on clock edge after strobe (1 cycle registered).
//  word_ack: sampled every cycle; if word_valid=1 -> clear slots, count, word_valid, overflow next cycle.
//   word_ack while word_valid=0 ignored. Ack same cycle as strobe: ack wins on buffer/valid;
//   decoder FSM, held, last_code still update from the byte (byte is not appended).
//  buf_full combinational from letter_count. F0/E0 bytes never touch last_code.
//  Reset mid-sequence (e.g. in BRK): FSM to IDLE; following byte treated as fresh.
// TESTING
//  1) Reset, send 1C,F0,1C,32,F0,32,5A -> word_codes[15:0]=16'h321C, count=2, word_valid=1, last_code=5A.
//  2) DEPTH=4: send 5 distinct letters with breaks -> count=4, buf_full=1, overflow=1, slot3=4th letter.
//  3) Send 1C,1C,1C (no break), F0,1C, then 1C -> REPEAT_BLOCK=1 gives count=2; REPEAT_BLOCK=0 gives 4.
//  4) Letters 21,23 then 66 -> count=1, slot1=00; 66 at count 0 -> no change, no underflow.
//  5) E0,75,E0,F0,75 (up arrow) -> no buffer/last_code change, FSM back in IDLE; next 1C appended.
//  6) word_valid=1, send letter -> ignored; word_ack -> count=0, valid=0, overflow=0; KEY low mid-F0 -> all 0.

Source files
------------

// File: rtl/ps2_word_capture.sv
// ----------------------------------------------------------------------------
// ps2_word_capture
//
// Consumes the byte stream from PS2_Controller, decodes scan-code set 2
// make / break (F0) / extended (E0) framing, and collects letter make codes
// into a small word buffer that supports Backspace and Enter editing. The
// most recently accepted make code is also exported for the HEX display.
//
// Parameters
//   DEPTH        letters held in the word buffer (1..16)
//   CNT_W        width of letter_count, must be able to hold 0..DEPTH
//   REPEAT_BLOCK 1: ignore typematic repeats of the held key until it is
//                released; 0: accept every make code
//
// Ports
//   CLOCK_50        in   system clock, all logic on rising edge
//   KEY[0]          in   asynchronous active-low reset
//   ps2_key_data    in   received byte
//   ps2_key_pressed in   one-cycle strobe, ps2_key_data valid
//   word_ack        in   consumer accepts the committed word, clears buffer
//   word_codes      out  letter codes, slot 0 in bits [7:0], empty slots 00
//   letter_count    out  number of letters held
//   word_valid      out  word committed by Enter, held until word_ack
//   letter_strobe   out  one-cycle pulse after a letter is appended
//   last_code       out  last accepted make code (non-extended keys)
//   buf_full        out  letter_count == DEPTH
//   overflow        out  sticky, a letter was dropped while full
// ----------------------------------------------------------------------------
module ps2_word_capture #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_W        = 3,
    parameter bit          REPEAT_BLOCK = 1'b1
) (
    input  logic               CLOCK_50,
    input  logic [0:0]         KEY,
    input  logic [7:0]         ps2_key_data,
    input  logic               ps2_key_pressed,
    input  logic               word_ack,
    output logic [8*DEPTH-1:0] word_codes,
    output logic [CNT_W-1:0]   letter_count,
    output logic               word_valid,
    output logic               letter_strobe,
    output logic [7:0]         last_code,
    output logic               buf_full,
    output logic               overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } state_e;

    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    logic rst_n;
    assign rst_n = KEY[0];

    state_e           state_q, state_d;
    logic [7:0]       slots_q [DEPTH];
    logic [7:0]       slots_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             strobe_q, strobe_d;
    logic [7:0]       last_q, last_d;
    logic [7:0]       held_q, held_d;
    logic             ovf_q, ovf_d;

    logic make_evt;
    logic accept;
    logic ack_hit;

    function automatic logic is_letter(input logic [7:0] c);
        case (c)
            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A:
                is_letter = 1'b1;
            default:
                is_letter = 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Decoder state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Decoder next state: only moves on a received byte
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (ps2_key_pressed) begin
            unique case (state_q)
                S_IDLE: begin
                    if (ps2_key_data == CODE_BRK) begin
                        state_d = S_BRK;
                    end else if (ps2_key_data == CODE_EXT) begin
                        state_d = S_EXT;
                    end
                end
                S_BRK:     state_d = S_IDLE;
                S_EXT:     state_d = (ps2_key_data == CODE_BRK) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / buffer next-state logic
    // ------------------------------------------------------------------
    assign make_evt = ps2_key_pressed && (state_q == S_IDLE)
                   && (ps2_key_data != CODE_BRK) && (ps2_key_data != CODE_EXT);
    // A repeat of the still-held key is discarded before anything else.
    assign accept   = make_evt && !(REPEAT_BLOCK && (ps2_key_data == held_q));
    assign ack_hit  = word_ack && valid_q;

    always_comb begin
        slots_d  = slots_q;
        count_d  = count_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        last_d   = last_q;
        held_d   = held_q;
        ovf_d    = ovf_q;

        // Releasing the held key re-arms it for a new make.
        if (ps2_key_pressed && (state_q == S_BRK) && (ps2_key_data == held_q)) begin
            held_d = '0;
        end

        if (accept) begin
            held_d = ps2_key_data;
            last_d = ps2_key_data;
            // A committed word is frozen until the consumer acknowledges it.
            if (!valid_q) begin
                if (is_letter(ps2_key_data)) begin
                    if (count_q < CNT_W'(DEPTH)) begin
                        for (int unsigned i = 0; i < DEPTH; i++) begin
                            if (CNT_W'(i) == count_q) begin
                                slots_d[i] = ps2_key_data;
                            end
                        end
                        count_d  = count_q + CNT_W'(1);
                        strobe_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (ps2_key_data == CODE_BKSP) begin
                    if (count_q != '0) begin
                        for (int unsigned i = 0; i < DEPTH; i++) begin
                            if (CNT_W'(i + 1) == count_q) begin
                                slots_d[i] = '0;
                            end
                        end
                        count_d = count_q - CNT_W'(1);
                    end
                end else if (ps2_key_data == CODE_ENTER) begin
                    if (count_q != '0) begin
                        valid_d = 1'b1;
                    end
                end
            end
        end

        // Acknowledge overrides any buffer edit from the same cycle; the
        // decoder, held key and last_code above still take the byte.
        if (ack_hit) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots_d[i] = '0;
            end
            count_d  = '0;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
            strobe_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Buffer / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            count_q  <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            last_q   <= '0;
            held_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            slots_q  <= slots_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            last_q   <= last_d;
            held_q   <= held_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        word_codes = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            word_codes[8*i +: 8] = slots_q[i];
        end
    end

    assign letter_count  = count_q;
    assign word_valid    = valid_q;
    assign letter_strobe = strobe_q;
    assign last_code     = last_q;
    assign buf_full      = (count_q == CNT_W'(DEPTH));
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_ps2_word_capture.sv
module tb_ps2_word_capture;

    localparam int DEPTH = 4;
    localparam logic [26*8-1:0] LETS = {
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

    logic       clk = 1'b0;
    logic [0:0] key;
    logic [7:0] data;
    logic       pressed;
    logic       ack;
    bit         started = 1'b0;
    bit         rand_ack = 1'b0;

    logic [31:0] wc    [2];
    logic [2:0]  cnt   [2];
    logic        valid [2];
    logic        strb  [2];
    logic [7:0]  last  [2];
    logic        full  [2];
    logic        ovf   [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ps2_word_capture #(.DEPTH(4), .CNT_W(3), .REPEAT_BLOCK(1'b1)) dut0 (
        .CLOCK_50(clk), .KEY(key), .ps2_key_data(data), .ps2_key_pressed(pressed),
        .word_ack(ack), .word_codes(wc[0]), .letter_count(cnt[0]),
        .word_valid(valid[0]), .letter_strobe(strb[0]), .last_code(last[0]),
        .buf_full(full[0]), .overflow(ovf[0]));

    ps2_word_capture #(.DEPTH(4), .CNT_W(3), .REPEAT_BLOCK(1'b0)) dut1 (
        .CLOCK_50(clk), .KEY(key), .ps2_key_data(data), .ps2_key_pressed(pressed),
        .word_ack(ack), .word_codes(wc[1]), .letter_count(cnt[1]),
        .word_valid(valid[1]), .letter_strobe(strb[1]), .last_code(last[1]),
        .buf_full(full[1]), .overflow(ovf[1]));

    function automatic bit is_let(input logic [7:0] c);
        for (int i = 0; i < 26; i++) begin
            if (LETS[8*i +: 8] == c) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h expected=%h at %0t", name, g, act, exp, $time);
        end
    endtask

    // Reference model: word as a queue, framing as two prefix flags.
    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam bit RB = (g == 0);
        logic [7:0]  q[$];
        logic [7:0]  held    = 8'h00;
        logic [7:0]  last_e  = 8'h00;
        bit          f0 = 1'b0, e0 = 1'b0;
        bit          valid_e = 1'b0, ovf_e = 1'b0, strb_e = 1'b0, ackh;
        logic [31:0] exp_wc  = '0;
        logic [2:0]  exp_cnt = '0;

        always @(posedge clk or negedge key[0]) begin
            if (!key[0]) begin
                q.delete();
                held = 8'h00; last_e = 8'h00; f0 = 1'b0; e0 = 1'b0;
                valid_e = 1'b0; ovf_e = 1'b0; strb_e = 1'b0;
            end else begin
                ackh   = ack && valid_e;
                strb_e = 1'b0;
                if (pressed) begin
                    if (e0 && f0) begin
                        e0 = 1'b0; f0 = 1'b0;
                    end else if (e0) begin
                        if (data == 8'hF0) f0 = 1'b1; else e0 = 1'b0;
                    end else if (f0) begin
                        if (data == held) held = 8'h00;
                        f0 = 1'b0;
                    end else if (data == 8'hF0) begin
                        f0 = 1'b1;
                    end else if (data == 8'hE0) begin
                        e0 = 1'b1;
                    end else if (!(RB && data == held)) begin
                        held   = data;
                        last_e = data;
                        if (!valid_e) begin
                            if (is_let(data)) begin
                                if (q.size() < DEPTH) begin
                                    q.push_back(data);
                                    strb_e = 1'b1;
                                end else begin
                                    ovf_e = 1'b1;
                                end
                            end else if (data == 8'h66) begin
                                if (q.size() > 0) void'(q.pop_back());
                            end else if (data == 8'h5A) begin
                                if (q.size() > 0) valid_e = 1'b1;
                            end
                        end
                    end
                end
                if (ackh) begin
                    q.delete(); valid_e = 1'b0; ovf_e = 1'b0;
                end
            end
            exp_wc = '0;
            for (int i = 0; i < q.size(); i++) exp_wc[8*i +: 8] = q[i];
            exp_cnt = 3'(q.size());
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            chk("word_codes", 0, wc[0], mdl[0].exp_wc);
            chk("count", 0, 32'(cnt[0]), 32'(mdl[0].exp_cnt));
            chk("valid", 0, 32'(valid[0]), 32'(mdl[0].valid_e));
            chk("strobe", 0, 32'(strb[0]), 32'(mdl[0].strb_e));
            chk("last_code", 0, 32'(last[0]), 32'(mdl[0].last_e));
            chk("buf_full", 0, 32'(full[0]), 32'(mdl[0].exp_cnt == 3'd4));
            chk("overflow", 0, 32'(ovf[0]), 32'(mdl[0].ovf_e));
            chk("word_codes", 1, wc[1], mdl[1].exp_wc);
            chk("count", 1, 32'(cnt[1]), 32'(mdl[1].exp_cnt));
            chk("valid", 1, 32'(valid[1]), 32'(mdl[1].valid_e));
            chk("strobe", 1, 32'(strb[1]), 32'(mdl[1].strb_e));
            chk("last_code", 1, 32'(last[1]), 32'(mdl[1].last_e));
            chk("buf_full", 1, 32'(full[1]), 32'(mdl[1].exp_cnt == 3'd4));
            chk("overflow", 1, 32'(ovf[1]), 32'(mdl[1].ovf_e));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        tick();
        data    = b;
        pressed = 1'b1;
        ack     = rand_ack ? ($urandom_range(0, 5) == 0) : 1'b0;
        tick();
        pressed = 1'b0;
        ack     = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic pulse_ack();
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk({tag, "_wc"}, g, wc[g], 32'h0);
            chk({tag, "_cnt_valid_ovf"}, g, {cnt[g], valid[g], ovf[g], full[g], strb[g]}, 32'h0);
            chk({tag, "_last"}, g, 32'(last[g]), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        key = 1'b1; data = 8'h00; pressed = 1'b0; ack = 1'b0;
        #1 key = 1'b0;
        started = 1'b1;
        tick(); tick();
        check_zero("reset");
        key = 1'b1;

        // Two letters with breaks, then Enter
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'h32); send(8'hF0); send(8'h32); send(8'h5A);
        chk("t1_wc", 0, 32'(wc[0][15:0]), 32'h321C);
        chk("t1_cnt", 0, 32'(cnt[0]), 32'd2);
        chk("t1_valid", 0, 32'(valid[0]), 32'd1);
        chk("t1_last", 0, 32'(last[0]), 32'h5A);
        pulse_ack();
        chk("t1_ack_cnt", 0, 32'(cnt[0]), 32'd0);

        // Five letters into a four-deep buffer
        send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'h32); send(8'hF0); send(8'h32);
        send(8'h21); send(8'hF0); send(8'h21);
        send(8'h23); send(8'hF0); send(8'h23);
        send(8'h24); send(8'hF0); send(8'h24);
        chk("t2_cnt", 0, 32'(cnt[0]), 32'd4);
        chk("t2_full", 0, 32'(full[0]), 32'd1);
        chk("t2_ovf", 0, 32'(ovf[0]), 32'd1);
        chk("t2_slot3", 0, 32'(wc[0][31:24]), 32'h23);
        send(8'h5A);
        pulse_ack();
        chk("t2_ack_ovf", 0, 32'(ovf[0]), 32'd0);

        // Typematic repeat handling
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        chk("t3_cnt_rb1", 0, 32'(cnt[0]), 32'd2);
        chk("t3_cnt_rb0", 1, 32'(cnt[1]), 32'd4);
        send(8'hF0); send(8'h1C); send(8'h5A);
        pulse_ack();

        // Backspace, including at empty buffer
        send(8'h21); send(8'hF0); send(8'h21); send(8'h23); send(8'hF0); send(8'h23); send(8'h66);
        chk("t4_cnt", 0, 32'(cnt[0]), 32'd1);
        chk("t4_slot1", 0, 32'(wc[0][15:8]), 32'h00);
        chk("t4_slot0", 0, 32'(wc[0][7:0]), 32'h21);
        send(8'hF0); send(8'h66); send(8'h66);
        send(8'hF0); send(8'h66); send(8'h66);
        chk("t4_empty_cnt", 0, 32'(cnt[0]), 32'd0);

        // Extended key make/break leaves everything alone
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        chk("t5_last", 0, 32'(last[0]), 32'h66);
        chk("t5_cnt", 0, 32'(cnt[0]), 32'd0);
        send(8'h1C);
        chk("t5_append", 0, wc[0], 32'h0000001C);

        // Frozen buffer while committed, then ack
        send(8'hF0); send(8'h1C); send(8'h5A);
        send(8'h32);
        chk("t6_frozen_cnt", 0, 32'(cnt[0]), 32'd1);
        chk("t6_last", 0, 32'(last[0]), 32'h32);
        pulse_ack();
        chk("t6_ack", 0, {cnt[0], valid[0], ovf[0]}, 32'h0);

        // Reset in the middle of a break sequence
        send(8'hF0);
        tick();
        key = 1'b0;
        tick();
        check_zero("t6_midreset");
        key = 1'b1;
        send(8'h1C);
        chk("t6_fresh", 0, wc[0], 32'h0000001C);

        // Randomised traffic with acks on the byte cycle and occasional resets
        rand_ack = 1'b1;
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 60) == 0) begin
                tick(); key = 1'b0; tick(); key = 1'b1;
            end
            case (r)
                0, 1, 2, 3: send(LETS[8*$urandom_range(0, 25) +: 8]);
                4:          send(8'hF0);
                5:          send(8'hE0);
                6:          send(8'h66);
                7:          send(8'h5A);
                default:    send(8'($urandom_range(0, 255)));
            endcase
        end
        rand_ack = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
